// File: rtl/count2421_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : count2421_pkg
// Purpose : Shared types, code constants and 2421-code helpers for the
//           count2421 counter and its step sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package count2421_pkg;

  // Sequencer states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_CHECK = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] CODE_ZERO = 4'b0000;
  localparam logic [3:0] CODE_NINE = 4'b1111;

  // Codes 0101..1010 never appear in 2421 weighting.
  function automatic logic is_valid_2421(input logic [3:0] code);
    return !((code >= 4'b0101) && (code <= 4'b1010));
  endfunction

  // Successor in 2421 order; 9 wraps to 0, illegal codes recover to 0.
  function automatic logic [3:0] next_2421(input logic [3:0] code);
    logic [3:0] nxt;
    nxt = code + 4'd1;
    if (code == 4'b0100)       nxt = 4'b1011;
    else if (code == CODE_NINE) nxt = CODE_ZERO;
    else if (!is_valid_2421(code)) nxt = CODE_ZERO;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count2421.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : count2421
// Purpose : Single-digit counter in 2421 code, advanced one step per cycle
//           that x is high.
// Revision: 1.0 - initial release
// ============================================================================
module count2421
  import count2421_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       x,
  output logic [3:0] out
);

  // Digit register: step to the next 2421 code whenever x is asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)  out <= CODE_ZERO;
    else if (x) out <= next_2421(out);
  end

endmodule
`default_nettype wire

// File: rtl/count2421_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : count2421_seq
// Purpose : Drives the x input of a count2421 digit to advance it n steps,
//           with GAP idle cycles after each check, counting 9->0 carries and
//           flagging illegal codes seen on the digit.
// Revision: 1.0 - initial release
// ============================================================================
module count2421_seq
  import count2421_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  input  logic [3:0]       digit_in,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             code_err
);

  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] remaining;
  logic [3:0]       gap_cnt;
  logic [3:0]       prev_code;

  // Next-state selection; remaining is already decremented when CHECK/GAP read it.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (n != '0) ? S_PULSE : S_DONE;
      S_PULSE: state_nx = S_CHECK;
      S_CHECK: begin
        if (HAS_GAP)             state_nx = S_GAP;
        else if (remaining != '0) state_nx = S_PULSE;
        else                      state_nx = S_DONE;
      end
      S_GAP:   if (gap_cnt == GAP_LAST) state_nx = (remaining != '0) ? S_PULSE : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs decoded from the next state).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
      prev_code <= CODE_ZERO;
      x         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_cnt <= '0;
      code_err  <= 1'b0;
    end else begin
      state <= state_nx;
      x     <= (state_nx == S_PULSE);
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= n;
            prev_code <= digit_in;
            carry_cnt <= '0;
            code_err  <= 1'b0;
          end
        end
        S_PULSE: remaining <= remaining - CNT_W'(1);
        S_CHECK: begin
          prev_code <= digit_in;
          gap_cnt   <= '0;
          if ((prev_code == CODE_NINE) && (digit_in == CODE_ZERO) && (carry_cnt != '1))
            carry_cnt <= carry_cnt + CNT_W'(1);
          if (!is_valid_2421(digit_in))
            code_err <= 1'b1;
        end
        S_GAP:   gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count2421_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_count2421_seq
// Purpose : Self-checking bench: two sequencer+counter pairs (GAP=1, GAP=0)
//           compared every cycle against a cycle-indexed job model, plus
//           directed literal checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_count2421_seq;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       start   = 1'b0;
  logic [3:0] n       = 4'd0;
  logic       inject1 = 1'b0;

  logic       x1, busy1, done1, err1;
  logic [3:0] cc1, out1, din1;
  logic       x0, busy0, done0, err0;
  logic [3:0] cc0, out0;

  int n_chk  = 0;
  int n_fail = 0;

  assign din1 = inject1 ? 4'b0110 : out1;

  always #5 clock = ~clock;

  count2421_seq #(.CNT_W(4), .GAP(1)) u_seq1 (
    .clock(clock), .reset(reset), .start(start), .n(n), .digit_in(din1),
    .x(x1), .busy(busy1), .done(done1), .carry_cnt(cc1), .code_err(err1));
  count2421 u_cnt1 (.clock(clock), .reset(reset), .x(x1), .out(out1));

  count2421_seq #(.CNT_W(4), .GAP(0)) u_seq0 (
    .clock(clock), .reset(reset), .start(start), .n(n), .digit_in(out0),
    .x(x0), .busy(busy0), .done(done0), .carry_cnt(cc0), .code_err(err0));
  count2421 u_cnt0 (.clock(clock), .reset(reset), .x(x0), .out(out0));

  // ---------------------------------------------------------------- model
  typedef struct {
    bit       active;
    int       k;       // index of the current cycle since the accepting edge
    int       nn;
    int       digit;   // decimal value held by the counter
    int       carry;
    bit       err;
    bit [3:0] prev;
    bit       x, busy, done;
  } mdl_t;

  mdl_t m1, m0;

  function automatic logic [3:0] code_of(input int d);
    case (d)
      0: return 4'b0000; 1: return 4'b0001; 2: return 4'b0010; 3: return 4'b0011;
      4: return 4'b0100; 5: return 4'b1011; 6: return 4'b1100; 7: return 4'b1101;
      8: return 4'b1110; default: return 4'b1111;
    endcase
  endfunction

  // One clock edge of the job: each step is P=2+g cycles (pulse, check, gaps),
  // the job is n*P cycles followed by one done cycle.
  function automatic mdl_t mstep(input mdl_t m, input int g, input bit st,
                                 input int nreq, input bit inj);
    mdl_t     r;
    int       p;
    int       j;
    bit [3:0] obs;
    r   = m;
    p   = 2 + g;
    obs = inj ? 4'b0110 : code_of(m.digit);
    if (!m.active) begin
      if (st) begin
        r.active = 1'b1; r.k = 1; r.nn = nreq;
        r.carry = 0; r.err = 1'b0; r.prev = obs;
      end
    end else begin
      j = m.nn * p;
      if (m.k <= j && ((m.k - 1) % p) == 1) begin
        if (m.prev == 4'hF && obs == 4'h0 && r.carry < 15) r.carry = r.carry + 1;
        if (obs inside {[4'h5:4'hA]}) r.err = 1'b1;
        r.prev = obs;
      end
      if (m.k == j + 1) begin r.active = 1'b0; r.k = 0; end
      else r.k = m.k + 1;
    end
    if (m.x) r.digit = (m.digit + 1) % 10;
    j      = r.nn * p;
    r.x    = r.active && r.k <= j && ((r.k - 1) % p) == 0;
    r.busy = r.active;
    r.done = r.active && r.k == j + 1;
    return r;
  endfunction

  // Model advances on the same edges as the DUT; reset clears it at once.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m1 <= '{default: 0};
      m0 <= '{default: 0};
    end else begin
      m1 <= mstep(m1, 1, start, int'(n), inject1);
      m0 <= mstep(m0, 0, start, int'(n), 1'b0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare both pairs against the model on every falling edge.
  always @(negedge clock) begin
    chk("x_g1", 32'(x1), 32'(m1.x));
    chk("busy_g1", 32'(busy1), 32'(m1.busy));
    chk("done_g1", 32'(done1), 32'(m1.done));
    chk("carry_g1", 32'(cc1), 32'(m1.carry));
    chk("err_g1", 32'(err1), 32'(m1.err));
    chk("code_g1", 32'(out1), 32'(code_of(m1.digit)));
    chk("x_g0", 32'(x0), 32'(m0.x));
    chk("busy_g0", 32'(busy0), 32'(m0.busy));
    chk("done_g0", 32'(done0), 32'(m0.done));
    chk("carry_g0", 32'(cc0), 32'(m0.carry));
    chk("err_g0", 32'(err0), 32'(m0.err));
    chk("code_g0", 32'(out0), 32'(code_of(m0.digit)));
  end

  // ---------------------------------------------------------------- directed
  task automatic wait_idle();
    int c;
    c = 0;
    while ((busy1 || busy0) && c < 200) begin @(negedge clock); c++; end
    chk("idle_wait", 32'(busy1 | busy0), 32'd0);
  endtask

  task automatic run_job(input int nreq, input int exp_c1, input int exp_c0,
                         input int exp_p1, input logic [3:0] exp_code1,
                         input int exp_carry1, input logic [3:0] exp_code0,
                         input int exp_carry0);
    int c1, c0, p1;
    c1 = 0; c0 = 0; p1 = 0;
    @(negedge clock); start = 1'b1; n = 4'(nreq);
    @(negedge clock); start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (x1) p1++;
      if (done1 && c1 == 0) c1 = c;
      if (done0 && c0 == 0) c0 = c;
      if (c1 != 0 && c0 != 0) break;
      @(negedge clock);
    end
    chk("done_cycle_g1", 32'(c1), 32'(exp_c1));
    chk("done_cycle_g0", 32'(c0), 32'(exp_c0));
    chk("pulses_g1", 32'(p1), 32'(exp_p1));
    chk("final_code_g1", 32'(out1), 32'(exp_code1));
    chk("final_carry_g1", 32'(cc1), 32'(exp_carry1));
    chk("final_code_g0", 32'(out0), 32'(exp_code0));
    chk("final_carry_g0", 32'(cc0), 32'(exp_carry0));
  endtask

  initial begin : main
    int p1, d1, dc1;
    #1 reset = 1'b1;
    #20;
    chk("rst_x", 32'({x1, x0}), 32'd0);
    chk("rst_busy", 32'({busy1, busy0}), 32'd0);
    chk("rst_done", 32'({done1, done0}), 32'd0);
    chk("rst_carry", 32'({cc1, cc0}), 32'd0);
    chk("rst_err", 32'({err1, err0}), 32'd0);
    #30 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_outs", 32'({x1, busy1, done1, cc1, err1}), 32'd0);

    // 10 steps from 0 wraps once; GAP=0 finishes in 21 cycles, GAP=1 in 31.
    run_job(10, 31, 21, 10, 4'b0000, 1, 4'b0000, 1);
    run_job(3, 10, 7, 3, 4'b0011, 0, 4'b0011, 0);
    run_job(4, 13, 9, 4, 4'b1101, 0, 4'b1101, 0);
    // From 7: 8, 9, 0, 1, 2 -> one carry.
    run_job(5, 16, 11, 5, 4'b0010, 1, 4'b0010, 1);
    // n=0 clears carry, no pulse, done right after the accepting edge.
    run_job(0, 1, 1, 0, 4'b0010, 0, 4'b0010, 0);

    // Start held high (and n changed) while GAP=1 pair is busy with n=4.
    p1 = 0; d1 = 0; dc1 = 0;
    @(negedge clock); start = 1'b1; n = 4'd4;
    @(negedge clock); n = 4'd15;
    for (int c = 1; c <= 20; c++) begin
      if (x1) p1++;
      if (done1) begin d1++; if (dc1 == 0) dc1 = c; start = 1'b0; end
      @(negedge clock);
    end
    start = 1'b0;
    chk("held_pulses_g1", 32'(p1), 32'd4);
    chk("held_dones_g1", 32'(d1), 32'd1);
    chk("held_done_cycle_g1", 32'(dc1), 32'd13);
    chk("held_code_g1", 32'(out1), 32'(4'b1100));
    wait_idle();

    // Illegal code forced during the first CHECK cycle.
    @(negedge clock); start = 1'b1; n = 4'd2;
    @(negedge clock); start = 1'b0;
    @(negedge clock); inject1 = 1'b1;
    @(negedge clock); inject1 = 1'b0;
    for (int c = 3; c <= 40 && !done1; c++) @(negedge clock);
    chk("err_at_done", 32'({done1, err1}), 32'b11);
    @(negedge clock);
    chk("err_sticky", 32'(err1), 32'd1);
    wait_idle();
    @(negedge clock); start = 1'b1; n = 4'd1;
    @(negedge clock); start = 1'b0;
    chk("err_cleared", 32'(err1), 32'd0);
    wait_idle();

    // Reset in the second GAP cycle (cycle 6 of a GAP=1 job).
    @(negedge clock); start = 1'b1; n = 4'd4;
    @(negedge clock); start = 1'b0;
    repeat (5) @(negedge clock);
    chk("pre_rst_busy", 32'(busy1), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_x", 32'({x1, x0}), 32'd0);
    chk("midrst_busy", 32'({busy1, busy0}), 32'd0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    d1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (done1 || done0) d1++;
    end
    chk("no_done_after_rst", 32'(d1), 32'd0);

    // Randomized traffic checked by the per-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      start   = ($urandom_range(0, 3) == 0);
      n       = 4'($urandom_range(0, 15));
      inject1 = ($urandom_range(0, 19) == 0);
    end
    @(negedge clock);
    start = 1'b0; inject1 = 1'b0;
    wait_idle();
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
